// File: rtl/uc_pkg.sv
// Shared definitions for the IO-capable control unit.
//   - opcode encodings decoded by uc_pila_io
//   - next-PC select encodings driven on s_pc_sel
//   - control FSM state encoding
package uc_pkg;

  localparam logic [5:0] OP_LDI  = 6'b000100;  // 0001xx, low two bits are don't-care
  localparam logic [5:0] OP_CALL = 6'b001100;
  localparam logic [5:0] OP_RET  = 6'b001101;
  localparam logic [5:0] OP_IN   = 6'b010100;
  localparam logic [5:0] OP_OUT  = 6'b010101;
  localparam logic [5:0] OP_OUTI = 6'b010110;
  localparam logic [5:0] OP_JZ   = 6'b111100;
  localparam logic [5:0] OP_JNZ  = 6'b111101;
  localparam logic [5:0] OP_JR   = 6'b111110;
  localparam logic [5:0] OP_JMP  = 6'b111111;

  localparam logic [1:0] PCS_INC = 2'b00;
  localparam logic [1:0] PCS_ABS = 2'b01;
  localparam logic [1:0] PCS_REL = 2'b10;
  localparam logic [1:0] PCS_STK = 2'b11;

  typedef enum logic [1:0] {
    EXEC    = 2'b00,
    IO_WAIT = 2'b01,
    ERR     = 2'b10
  } uc_state_e;

  function automatic logic is_io_op(input logic [5:0] op);
    return (op == OP_IN) || (op == OP_OUT) || (op == OP_OUTI);
  endfunction

endpackage

// File: rtl/uc_pila.sv
// Return-address LIFO for CALL/RET.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, pop         request strobes (never both in one cycle)
//   data_in [PCW]     value pushed on push
//   top [PCW]         entry[count-1], 0 when empty
//   full, empty       count == STACK_DEPTH / count == 0
// A push while full or a pop while empty is ignored, so stored entries
// are never disturbed by overflow/underflow.
module uc_pila #(
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] data_in,
  output logic [PCW-1:0] top,
  output logic           full,
  output logic           empty
);

  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [CW-1:0]  count_q, count_d;
  logic [PCW-1:0] entry_q [STACK_DEPTH];
  logic [PCW-1:0] entry_d [STACK_DEPTH];

  assign full  = (count_q == CW'(STACK_DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    for (int i = 0; i < STACK_DEPTH; i++) entry_d[i] = entry_q[i];
    if (push && !full) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        if (count_q == CW'(i)) entry_d[i] = data_in;
      count_d = count_q + CW'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end
  end

  // Loop-based select keeps the index width independent of CW.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++)
      if (count_q == CW'(i + 1)) top = entry_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: rtl/uc_pila_io.sv
// Control unit with return-address stack, IO handshake and IO timeout.
// Decodes the 6-bit opcode into datapath strobes; stalls the PC while an
// IO access waits for io_ack; a stack fault or IO timeout locks the unit
// in a sticky error state until reset.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   z, opcode, pc_in        ALU zero flag, opcode, current PC
//   io_ack                  IO completion strobe
//   s_*                     datapath strobes (ALU op, regfile, IO, PC mux)
//   ret_addr                stack top
//   stack_full/stack_empty  stack status
//   s_err                   sticky error
//
// state   | meaning
// EXEC    | normal one-cycle execution, IO issued here
// IO_WAIT | IO request outstanding, PC stalled, timeout counting
// ERR     | stack fault or IO timeout; everything idle until reset
module uc_pila_io
  import uc_pkg::*;
#(
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4,
  parameter int IO_TIMEOUT  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           z,
  input  logic [5:0]     opcode,
  input  logic [PCW-1:0] pc_in,
  input  logic           io_ack,
  output logic [2:0]     s_op,
  output logic           s_inm_alu,
  output logic           s_we3,
  output logic           s_WA3,
  output logic           s_io_alu,
  output logic           s_inm_rd,
  output logic           s_io,
  output logic           s_io_enable,
  output logic [1:0]     s_pc_sel,
  output logic           s_pc_we,
  output logic [PCW-1:0] ret_addr,
  output logic           stack_full,
  output logic           stack_empty,
  output logic           s_err
);

  localparam int TW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT + 1) : 1;

  uc_state_e     state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  logic          io_op;

  uc_pila #(
    .PCW        (PCW),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_pila (
    .clk    (clk),
    .rst_n  (reset),
    .push   (push),
    .pop    (pop),
    .data_in(pc_in + PCW'(1)),
    .top    (ret_addr),
    .full   (stack_full),
    .empty  (stack_empty)
  );

  assign io_op = is_io_op(opcode);
  assign s_err = (state_q == ERR);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    s_op        = '0;
    s_inm_alu   = 1'b0;
    s_we3       = 1'b0;
    s_WA3       = 1'b1;
    s_io_alu    = 1'b0;
    s_inm_rd    = 1'b0;
    s_io        = 1'b0;
    s_io_enable = 1'b0;
    s_pc_sel    = PCS_INC;
    s_pc_we     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    // IO strobes are the same in EXEC and IO_WAIT; the stalled PC keeps
    // the opcode stable while waiting.
    if (io_op && state_q != ERR) begin
      s_io_enable = 1'b1;
      s_io_alu    = 1'b1;
      s_WA3       = 1'b0;
      s_io        = (opcode != OP_IN);
      s_inm_rd    = (opcode == OP_OUTI);
    end

    case (state_q)
      EXEC: begin
        s_pc_we = 1'b1;
        cnt_d   = '0;
        if (!opcode[2]) begin
          s_op  = opcode[5:3];
          s_we3 = 1'b1;
        end else if (opcode[5:2] == OP_LDI[5:2]) begin
          s_inm_alu = 1'b1;
          s_we3     = 1'b1;
        end else begin
          case (opcode)
            OP_CALL: begin
              s_pc_sel = PCS_ABS;
              if (stack_full) begin
                s_pc_we = 1'b0;
                state_d = ERR;
              end else begin
                push = 1'b1;
              end
            end
            OP_RET: begin
              s_pc_sel = PCS_STK;
              if (stack_empty) begin
                s_pc_we = 1'b0;
                state_d = ERR;
              end else begin
                pop = 1'b1;
              end
            end
            OP_IN, OP_OUT, OP_OUTI: begin
              if (io_ack) begin
                s_we3 = (opcode == OP_IN);
              end else begin
                s_pc_we = 1'b0;
                state_d = IO_WAIT;
              end
            end
            OP_JZ:   s_pc_sel = z ? PCS_ABS : PCS_INC;
            OP_JNZ:  s_pc_sel = z ? PCS_INC : PCS_ABS;
            OP_JR:   s_pc_sel = PCS_REL;
            OP_JMP:  s_pc_sel = PCS_ABS;
            default: ;
          endcase
        end
      end

      IO_WAIT: begin
        if (!io_op) begin
          // Opcode changed under a stall: drop the access without writing.
          cnt_d   = '0;
          state_d = EXEC;
        end else if (io_ack) begin
          s_pc_we = 1'b1;
          s_we3   = (opcode == OP_IN);
          cnt_d   = '0;
          state_d = EXEC;
        end else if (IO_TIMEOUT != 0 && (int'(cnt_q) + 1) >= IO_TIMEOUT) begin
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      ERR: begin
        s_pc_we = 1'b0;
      end

      default: state_d = ERR;
    endcase

    // Outputs are idle as soon as reset falls, including mid-IO_WAIT.
    if (!reset) begin
      s_op        = '0;
      s_inm_alu   = 1'b0;
      s_we3       = 1'b0;
      s_WA3       = 1'b1;
      s_io_alu    = 1'b0;
      s_inm_rd    = 1'b0;
      s_io        = 1'b0;
      s_io_enable = 1'b0;
      s_pc_sel    = PCS_INC;
      s_pc_we     = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EXEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uc_pila_io.sv
module tb_uc_pila_io;

  localparam int PCW = 10;

  logic           clk = 1'b0;
  logic           reset;
  logic           z;
  logic [5:0]     opcode;
  logic [PCW-1:0] pc_in;
  logic           io_ack;
  logic [2:0]     s_op;
  logic           s_inm_alu, s_we3, s_WA3, s_io_alu, s_inm_rd, s_io, s_io_enable;
  logic [1:0]     s_pc_sel;
  logic           s_pc_we;
  logic [PCW-1:0] ret_addr;
  logic           stack_full, stack_empty, s_err;

  int n_chk = 0;
  int n_fail = 0;

  uc_pila_io #(.PCW(PCW), .STACK_DEPTH(4), .IO_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .z(z), .opcode(opcode), .pc_in(pc_in),
    .io_ack(io_ack), .s_op(s_op), .s_inm_alu(s_inm_alu), .s_we3(s_we3),
    .s_WA3(s_WA3), .s_io_alu(s_io_alu), .s_inm_rd(s_inm_rd), .s_io(s_io),
    .s_io_enable(s_io_enable), .s_pc_sel(s_pc_sel), .s_pc_we(s_pc_we),
    .ret_addr(ret_addr), .stack_full(stack_full), .stack_empty(stack_empty),
    .s_err(s_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock, leaving time 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs mid-cycle and let the combinational decode settle.
  task automatic drive(input logic [5:0] op, input logic zz, input logic ack,
                       input logic [PCW-1:0] pc);
    opcode = op;
    z      = zz;
    io_ack = ack;
    pc_in  = pc;
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(6'b000000, 1'b0, 1'b0, 10'h000);
    #2;
    // 1: reset state and ALU decode
    check_eq("rst_we3", s_we3, 0);
    check_eq("rst_pc_we", s_pc_we, 0);
    check_eq("rst_wa3", s_WA3, 1);
    check_eq("rst_pc_sel", s_pc_sel, 0);
    check_eq("rst_err", s_err, 0);
    check_eq("rst_empty", stack_empty, 1);
    check_eq("rst_ret", ret_addr, 0);
    tick();
    reset = 1'b1;
    #1;
    check_eq("alu0_op", s_op, 3'b000);
    check_eq("alu0_we3", s_we3, 1);
    check_eq("alu0_pc_we", s_pc_we, 1);
    check_eq("alu0_pc_sel", s_pc_sel, 0);
    drive(6'b101011, 1'b0, 1'b0, 10'h001);
    check_eq("alu5_op", s_op, 3'b101);
    check_eq("alu5_wa3", s_WA3, 1);

    // 2: CALL/CALL/RET/RET
    tick();
    drive(6'b001100, 1'b0, 1'b0, 10'h010);
    check_eq("call1_sel", s_pc_sel, 2'b01);
    check_eq("call1_we", s_pc_we, 1);
    tick();
    check_eq("call1_ret", ret_addr, 10'h011);
    check_eq("call1_empty", stack_empty, 0);
    drive(6'b001100, 1'b0, 1'b0, 10'h020);
    tick();
    check_eq("call2_ret", ret_addr, 10'h021);
    drive(6'b001101, 1'b0, 1'b0, 10'h100);
    check_eq("ret1_sel", s_pc_sel, 2'b11);
    check_eq("ret1_top", ret_addr, 10'h021);
    check_eq("ret1_we", s_pc_we, 1);
    tick();
    check_eq("ret2_top", ret_addr, 10'h011);
    check_eq("ret2_sel", s_pc_sel, 2'b11);
    tick();
    check_eq("ret_empty", stack_empty, 1);
    check_eq("ret_top0", ret_addr, 0);

    // 3: overflow on the fifth CALL
    for (int i = 0; i < 4; i++) begin
      drive(6'b001100, 1'b0, 1'b0, PCW'(10'h040 + i));
      check_eq("ovf_call_we", s_pc_we, 1);
      tick();
    end
    check_eq("ovf_full", stack_full, 1);
    drive(6'b001100, 1'b0, 1'b0, 10'h3ff);
    check_eq("ovf_last_we", s_pc_we, 0);
    tick();
    check_eq("ovf_err", s_err, 1);
    check_eq("ovf_top_kept", ret_addr, 10'h044);
    drive(6'b000000, 1'b0, 1'b1, 10'h000);
    check_eq("err_alu_we3", s_we3, 0);
    check_eq("err_pc_we", s_pc_we, 0);
    tick();
    check_eq("err_sticky", s_err, 1);
    check_eq("err_ioen", s_io_enable, 0);
    pulse_reset();
    check_eq("err_cleared", s_err, 0);
    check_eq("err_alu_after", s_we3, 1);

    // 4: IN with three stalled cycles
    tick();
    drive(6'b010100, 1'b0, 1'b0, 10'h050);
    for (int i = 0; i < 3; i++) begin
      check_eq("in_wait_pc_we", s_pc_we, 0);
      check_eq("in_wait_ioen", s_io_enable, 1);
      check_eq("in_wait_we3", s_we3, 0);
      check_eq("in_wait_wa3", s_WA3, 0);
      tick();
    end
    drive(6'b010100, 1'b0, 1'b1, 10'h050);
    check_eq("in_ack_we3", s_we3, 1);
    check_eq("in_ack_wa3", s_WA3, 0);
    check_eq("in_ack_pc_we", s_pc_we, 1);
    check_eq("in_ack_io", s_io, 0);
    tick();
    drive(6'b010110, 1'b0, 1'b1, 10'h051);
    check_eq("outi_inm_rd", s_inm_rd, 1);
    check_eq("outi_io", s_io, 1);
    check_eq("outi_we3", s_we3, 0);
    check_eq("outi_pc_we", s_pc_we, 1);

    // 5: OUT timeout after 16 IO_WAIT cycles
    tick();
    drive(6'b010101, 1'b0, 1'b0, 10'h060);
    check_eq("out_exec_we", s_pc_we, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq("out_wait_err", s_err, 0);
      check_eq("out_wait_we3", s_we3, 0);
      check_eq("out_wait_ioen", s_io_enable, 1);
    end
    tick();
    check_eq("out_timeout_err", s_err, 1);
    check_eq("out_timeout_ioen", s_io_enable, 0);
    check_eq("out_timeout_we3", s_we3, 0);
    pulse_reset();

    // 6: branches, LDI, NOP
    drive(6'b111100, 1'b1, 1'b0, 10'h070);
    check_eq("jz_z1", s_pc_sel, 2'b01);
    drive(6'b111100, 1'b0, 1'b0, 10'h070);
    check_eq("jz_z0", s_pc_sel, 2'b00);
    drive(6'b111101, 1'b0, 1'b0, 10'h070);
    check_eq("jnz_z0", s_pc_sel, 2'b01);
    drive(6'b111101, 1'b1, 1'b0, 10'h070);
    check_eq("jnz_z1", s_pc_sel, 2'b00);
    drive(6'b111110, 1'b0, 1'b0, 10'h070);
    check_eq("jr", s_pc_sel, 2'b10);
    drive(6'b111111, 1'b0, 1'b0, 10'h070);
    check_eq("jmp", s_pc_sel, 2'b01);
    drive(6'b000110, 1'b0, 1'b0, 10'h070);
    check_eq("ldi_inm", s_inm_alu, 1);
    check_eq("ldi_we3", s_we3, 1);
    drive(6'b001110, 1'b0, 1'b0, 10'h070);
    check_eq("nop_we3", s_we3, 0);
    check_eq("nop_pc_we", s_pc_we, 1);

    // Reset in the middle of IO_WAIT
    tick();
    drive(6'b010100, 1'b0, 1'b0, 10'h080);
    tick();
    tick();
    check_eq("mid_wait_ioen", s_io_enable, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_ioen", s_io_enable, 0);
    check_eq("mid_rst_we3", s_we3, 0);
    check_eq("mid_rst_pc_we", s_pc_we, 0);
    drive(6'b000000, 1'b0, 1'b0, 10'h000);
    reset = 1'b1;
    #1;
    check_eq("mid_rel_we3", s_we3, 1);
    check_eq("mid_rel_pc_we", s_pc_we, 1);
    check_eq("mid_rel_err", s_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_pila_io.md
Name: uc_pila_io

Overview:
- Parametrised successor control unit for the IO-capable CPU.
- Decodes the 6-bit opcode into datapath strobes.
- Adds a hardware return-address stack for CALL/RET and a req/ack IO handshake that stalls the PC.
- Adds an IO timeout and a sticky error state.
- Sits between the instruction memory opcode field and the datapath: PC mux, register file, ALU and IO ports.

Parameters:
- PCW, 10, program-counter width in bits.
- STACK_DEPTH, 4, return-address stack entries (≥2).
- IO_TIMEOUT, 16, maximum IO_WAIT cycles before error; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- z  in  1  ALU zero flag.
- opcode  in  6  current instruction opcode.
- pc_in  in  PCW  current PC value.
- io_ack  in  1  IO port completion strobe.
- s_op  out  3  ALU operation.
- s_inm_alu  out  1  ALU/regfile input from immediate.
- s_we3  out  1  register-file write enable.
- s_WA3  out  1  write-address select (1 = instruction rd field).
- s_io_alu  out  1  register-file write data from IO.
- s_inm_rd  out  1  IO output data from immediate.
- s_io  out  1  IO direction (1 = output).
- s_io_enable  out  1  IO request, held until ack.
- s_pc_sel  out  2  next PC: 00 = +1, 01 = absolute immediate, 10 = relative immediate, 11 = stack top.
- s_pc_we  out  1  PC load enable (0 = stall).
- ret_addr  out  PCW  stack top.
- stack_full  out  1  stack count == STACK_DEPTH.
- stack_empty  out  1  stack count == 0.
- s_err  out  1  sticky error.

Behaviour:
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous and active-low.
- Reset (reset=0, asynchronous):
  - state=EXEC, stack count=0, timeout counter=0, s_err=0, all entries 0.
  - While reset is low, all strobes are 0, s_pc_sel=00, s_WA3=1.
- Decode is combinational from state, opcode, z and io_ack; state, stack and counter are registered.
- Non-IO instructions complete in one cycle with s_pc_we=1 and s_pc_sel=00 unless stated otherwise.
- Opcode map (any unlisted opcode is a NOP: pc +1 only):
  - opcode[2]==0: ALU operation. s_op=opcode[5:3], s_we3=1, s_WA3=1.
  - 0001xx: load immediate. s_inm_alu=1, s_we3=1.
  - 001100 CALL:
    - Push pc_in+1 (mod 2^PCW), s_pc_sel=01.
    - If stack_full: no push, s_pc_we=0, go to ERR.
  - 001101 RET:
    - s_pc_sel=11, pop.
    - If stack_empty: s_pc_we=0, go to ERR.
  - 010100 IN: s_io_enable=1, s_io_alu=1, s_WA3=0. s_we3=1 only in the cycle io_ack=1.
  - 010101 OUT: s_io_enable=1, s_io=1, s_io_alu=1, s_WA3=0.
  - 010110 OUT-immediate: as OUT, plus s_inm_rd=1.
  - 111100 JZ: s_pc_sel=01 if z, else 00.
  - 111101 JNZ: s_pc_sel=01 if !z, else 00.
  - 111110 JR: s_pc_sel=10.
  - 111111 JMP: s_pc_sel=01.
- IO handshake:
  - In EXEC with an IO opcode and io_ack=1: completes this cycle, s_pc_we=1.
  - With io_ack=0: s_pc_we=0, s_we3=0, next state IO_WAIT.
  - IO_WAIT holds the same IO strobes (decoded from opcode, which the stalled PC keeps stable) and counts cycles.
  - On io_ack=1: complete (s_pc_we=1, s_we3=1 for IN), counter cleared, back to EXEC.
  - If IO_TIMEOUT≠0 and the counter reaches IO_TIMEOUT without ack: go to ERR with no write.
- ERR:
  - s_err=1; s_pc_we, s_we3, s_io_enable and push/pop all 0.
  - Leaves only on reset.
  - io_ack is ignored.
- Stack:
  - LIFO; ret_addr = entry[count-1], or 0 when empty.
  - Push and pop never occur in the same cycle.
  - count saturates at 0..STACK_DEPTH.
  - Overflow/underflow never corrupts stored entries.
- Reset mid-IO_WAIT: abort immediately, with no register write.

Decomposition:
- Shared package uc_pkg holds:
  - opcode localparams (OP_LDI, OP_CALL, OP_RET, OP_IN, OP_OUT, OP_OUTI, OP_JZ, OP_JNZ, OP_JR, OP_JMP);
  - PC-select encodings PCS_INC/ABS/REL/STK;
  - state encoding EXEC/IO_WAIT/ERR.
- One sub-module, uc_pila:
  - Parametrised LIFO (PCW, STACK_DEPTH) with push, pop, data_in, top, full, empty.
  - Asynchronous active-low reset.

Test Plan:
1. Reset low, then opcode=000000 (ALU) → after release: s_op=000, s_we3=1, s_pc_we=1, s_pc_sel=00; opcode=101011 → s_op=101.
2. CALL at pc_in=0x010, then CALL at pc_in=0x020, then RET, RET → ret_addr 0x011, then 0x021; RETs give s_pc_sel=11 with tops 0x021 then 0x011; stack_empty=1 at the end.
3. STACK_DEPTH+1 consecutive CALLs → last CALL: s_pc_we=0, s_err=1 and stays 1; a following ALU opcode still gives s_we3=0 until reset.
4. IN with io_ack=0 for 3 cycles then 1 → s_pc_we=0 and s_io_enable=1 for 3 cycles; on ack cycle s_we3=1, s_WA3=0, s_pc_we=1.
5. OUT with io_ack held low and IO_TIMEOUT=16 → s_err=1 after 16 IO_WAIT cycles, s_we3 never asserted.
6. JZ with z=1 → s_pc_sel=01; JZ with z=0 → 00; JNZ with z=0 → 01; JR → 10; reset asserted mid-IO_WAIT → outputs immediately cleared, state EXEC after release.
